// File: rtl/bus_ram_responder_pkg.sv
// Shared types for the OCP-style RAM responder.
//   ocp_cmd_e    : master command encoding (IDLE/WR/RD, other codes act as IDLE)
//   ocp_resp_e   : slave response encoding (NULL/DVA/ERR)
//   resp_entry_t : one queued response, {err, data}
//   wrap_inc     : pointer increment modulo an arbitrary depth
package bus_ram_responder_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int BE_WIDTH   = 4;

  typedef enum logic [2:0] {
    CMD_IDLE = 3'd0,
    CMD_WR   = 3'd1,
    CMD_RD   = 3'd2
  } ocp_cmd_e;

  typedef enum logic [1:0] {
    RESP_NULL = 2'd0,
    RESP_DVA  = 2'd1,
    RESP_ERR  = 2'd3
  } ocp_resp_e;

  typedef struct packed {
    logic                  err;
    logic [DATA_WIDTH-1:0] data;
  } resp_entry_t;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic int unsigned wrap_inc(int unsigned ptr, int unsigned depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/bus_ram_responder_if.sv
// OCP-style command/response bus between a master and the RAM responder.
//   MCmd/MAddr/MData/MByteEn : command phase, master -> slave
//   SCmdAccept               : slave takes the command this cycle
//   SResp/SData              : response phase, slave -> master
//   MRespAccept              : master takes the response this cycle
// Handshake: a command transfers in any cycle where MCmd is WR or RD and
// SCmdAccept=1; a response transfers in any cycle where SResp!=NULL and
// MRespAccept=1. The slave holds SResp/SData stable until that transfer.
interface bus_ram_responder_if #(
  parameter int ADDR_WIDTH = 32
);
  import bus_ram_responder_pkg::*;

  logic [2:0]            MCmd;
  logic [ADDR_WIDTH-1:0] MAddr;
  logic [DATA_WIDTH-1:0] MData;
  logic [BE_WIDTH-1:0]   MByteEn;
  logic                  SCmdAccept;
  logic [1:0]            SResp;
  logic [DATA_WIDTH-1:0] SData;
  logic                  MRespAccept;

  modport master (
    output MCmd, MAddr, MData, MByteEn, MRespAccept,
    input  SCmdAccept, SResp, SData
  );

  modport slave (
    input  MCmd, MAddr, MData, MByteEn, MRespAccept,
    output SCmdAccept, SResp, SData
  );

endinterface

// File: rtl/bus_ram_responder_resp_fifo.sv
// In-order response FIFO with a registered head.
//   clk, rst_n      : clock, asynchronous active-low reset
//   push_i          : write {push_err_i, push_data_i} at the tail
//   pop_i           : drop the head (ignored when empty)
//   empty_o         : no entry presented
//   head_err_o      : presented entry is an error response
//   head_data_o     : presented entry data (0 when empty)
// The head registers are loaded with the entry that will be at the front
// after this cycle's push/pop, so the output never passes through
// combinational logic from push/pop.
module bus_ram_responder_resp_fifo
  import bus_ram_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic                  push_err_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic                  empty_o,
  output logic                  head_err_o,
  output logic [DATA_WIDTH-1:0] head_data_o
);

  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  resp_entry_t mem_q [DEPTH];

  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [CNTW-1:0] remain;
  logic            head_valid_q, head_valid_d;
  resp_entry_t     head_q, head_d;
  logic            do_pop;
  logic            full;

  assign do_pop = pop_i && head_valid_q;
  assign full   = (count_q == CNTW'(DEPTH));

  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    head_valid_d = head_valid_q;
    head_d       = head_q;
    remain       = count_q - CNTW'(do_pop);
    if (do_pop) rd_ptr_d = PTRW'(wrap_inc(32'(rd_ptr_q), DEPTH));
    if (push_i) wr_ptr_d = PTRW'(wrap_inc(32'(wr_ptr_q), DEPTH));
    count_d = remain + CNTW'(push_i);
    // Entries surviving the pop are already in storage; only when the
    // FIFO would be empty does an incoming push go straight to the head.
    if (remain != '0) begin
      head_valid_d = 1'b1;
      head_d       = mem_q[rd_ptr_d];
    end else if (push_i) begin
      head_valid_d = 1'b1;
      head_d       = '{err: push_err_i, data: push_data_i};
    end else begin
      head_valid_d = 1'b0;
      head_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      head_valid_q <= 1'b0;
      head_q       <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      head_valid_q <= head_valid_d;
      head_q       <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= '{err: push_err_i, data: push_data_i};
  end

  assign empty_o     = !head_valid_q;
  assign head_err_o  = head_q.err;
  assign head_data_o = head_q.data;

  // Credits bound outstanding reads to DEPTH, so a full FIFO never sees a push.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full));

endmodule

// File: rtl/bus_ram_responder.sv
// OCP-style bus responder in front of a fixed-latency single-port RAM.
//   clk, reset      : clock, asynchronous active-low reset
//   bus             : command/response bus (slave side)
//   ram_en/ram_we   : RAM strobe and write select (combinational from MCmd)
//   ram_addr        : RAM word address
//   ram_be/ram_wdata: write byte enables and data
//   ram_rdata       : RAM read data, RAM_LATENCY cycles after ram_en
//   credits_o       : debug view of the response credit counter
// Writes are posted. Reads are tagged in a RAM_LATENCY-deep pipe so their
// data (or an error marker for out-of-range addresses) lands in the
// response FIFO in acceptance order. A credit counter covers both the pipe
// and the FIFO so a read is only accepted when its response has a slot.
module bus_ram_responder
  import bus_ram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_WORDS   = 4096,
  parameter int RAM_LATENCY = 1,
  parameter int RESP_DEPTH  = 4,
  localparam int RAM_AW     = $clog2(MEM_WORDS),
  localparam int CW         = $clog2(RESP_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  bus_ram_responder_if.slave    bus,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [RAM_AW-1:0]     ram_addr,
  output logic [BE_WIDTH-1:0]   ram_be,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [CW-1:0]         credits_o
);

  logic is_wr, is_rd, in_range, wr_acc, rd_acc, pop;
  logic [CW-1:0] credits_q, credits_d;
  logic [RAM_LATENCY-1:0] pipe_valid_q, pipe_valid_d;
  logic [RAM_LATENCY-1:0] pipe_err_q, pipe_err_d;
  logic push, push_err;
  logic [DATA_WIDTH-1:0] push_data;
  logic fifo_empty, head_err;
  logic [DATA_WIDTH-1:0] head_data;

  // Gating with reset keeps the RAM quiet while reset is held, even though
  // the command path is otherwise purely combinational.
  assign is_wr    = reset && (bus.MCmd == CMD_WR);
  assign is_rd    = reset && (bus.MCmd == CMD_RD);
  assign in_range = (bus.MAddr < ADDR_WIDTH'(MEM_WORDS));
  assign wr_acc   = is_wr;
  assign rd_acc   = is_rd && (credits_q != '0);

  assign bus.SCmdAccept = wr_acc || rd_acc;
  assign ram_en         = (wr_acc || rd_acc) && in_range;
  assign ram_we         = wr_acc && in_range;
  assign ram_addr       = bus.MAddr[RAM_AW-1:0];
  assign ram_be         = bus.MByteEn;
  assign ram_wdata      = bus.MData;

  // Read tag pipe: stage RAM_LATENCY-1 lines up with valid ram_rdata.
  always_comb begin
    pipe_valid_d    = pipe_valid_q;
    pipe_err_d      = pipe_err_q;
    pipe_valid_d[0] = rd_acc;
    pipe_err_d[0]   = rd_acc && !in_range;
    for (int i = 1; i < RAM_LATENCY; i++) begin
      pipe_valid_d[i] = pipe_valid_q[i-1];
      pipe_err_d[i]   = pipe_err_q[i-1];
    end
  end

  assign push      = pipe_valid_q[RAM_LATENCY-1];
  assign push_err  = pipe_err_q[RAM_LATENCY-1];
  assign push_data = push_err ? '0 : ram_rdata;

  assign pop = !fifo_empty && bus.MRespAccept;

  always_comb begin
    credits_d = credits_q;
    if (rd_acc && !pop)      credits_d = credits_q - CW'(1);
    else if (!rd_acc && pop) credits_d = credits_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credits_q    <= CW'(RESP_DEPTH);
      pipe_valid_q <= '0;
      pipe_err_q   <= '0;
    end else begin
      credits_q    <= credits_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_err_q   <= pipe_err_d;
    end
  end

  bus_ram_responder_resp_fifo #(
    .DEPTH(RESP_DEPTH)
  ) u_resp_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (push),
    .push_err_i  (push_err),
    .push_data_i (push_data),
    .pop_i       (pop),
    .empty_o     (fifo_empty),
    .head_err_o  (head_err),
    .head_data_o (head_data)
  );

  assign bus.SResp = fifo_empty ? RESP_NULL : (head_err ? RESP_ERR : RESP_DVA);
  assign bus.SData = head_data;
  assign credits_o = credits_q;

endmodule

// File: tb/tb_bus_ram_responder.sv
module tb_bus_ram_responder;

  localparam int W = 66;  // {ready_cycle[31:0], resp[1:0], data[31:0]}

  logic        clk;
  logic        reset;
  logic        ram_en, ram_we;
  logic [11:0] ram_addr;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata, ram_rdata;
  logic [2:0]  credits_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [W-1:0]  exp_q[$];
  logic [31:0]   model_mem [int];
  logic [31:0]   ram_mem [4096];

  bus_ram_responder_if #(.ADDR_WIDTH(32)) bus ();

  bus_ram_responder dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_be    (ram_be),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .credits_o (credits_o)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Environment RAM, one cycle of read latency.
  initial begin
    for (int i = 0; i < 4096; i++) ram_mem[i] = 32'h1000_0000 + i;
  end

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= ram_mem[ram_addr];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_read(input int a);
    if (model_mem.exists(a)) return model_mem[a];
    return 32'h1000_0000 + a;
  endfunction

  // Scoreboard: reference behaviour of the bus, checked every cycle.
  always @(negedge clk) begin : cmp_proc
    logic        is_wr, is_rd, in_rng, exp_acc, has_resp;
    logic [W-1:0] head, ent;
    logic [31:0] rdy, exp_data, old;
    logic [1:0]  exp_resp;
    int          a;
    if (!reset) begin
      chk("rst_accept",  32'(bus.SCmdAccept), 32'd0);
      chk("rst_ram_en",  32'(ram_en),         32'd0);
      chk("rst_sresp",   32'(bus.SResp),      32'd0);
      chk("rst_sdata",   bus.SData,           32'd0);
      chk("rst_credits", 32'(credits_o),      32'd4);
      exp_q.delete();
    end else begin
      is_wr   = (bus.MCmd == 3'd1);
      is_rd   = (bus.MCmd == 3'd2);
      in_rng  = (bus.MAddr < 32'd4096);
      exp_acc = is_wr || (is_rd && exp_q.size() < 4);
      a       = int'(bus.MAddr[11:0]);
      chk("accept",  32'(bus.SCmdAccept), 32'(exp_acc));
      chk("ram_en",  32'(ram_en),         32'(exp_acc && in_rng));
      chk("ram_we",  32'(ram_we),         32'(is_wr && in_rng));
      if (exp_acc && in_rng) chk("ram_addr", 32'(ram_addr), 32'(a));
      chk("credits", 32'(credits_o), 32'(4 - exp_q.size()));
      has_resp = 1'b0;
      exp_resp = 2'd0;
      exp_data = 32'd0;
      if (exp_q.size() > 0) begin
        head = exp_q[0];
        rdy  = head[65:34];
        if (int'(rdy) <= cyc) begin
          has_resp = 1'b1;
          exp_resp = head[33:32];
          exp_data = head[31:0];
        end
      end
      chk("sresp", 32'(bus.SResp), 32'(exp_resp));
      chk("sdata", bus.SData,      exp_data);
      if (has_resp && bus.MRespAccept) void'(exp_q.pop_front());
      if (is_rd && exp_acc) begin
        ent = {32'(cyc + 2), (in_rng ? 2'd1 : 2'd3), (in_rng ? model_read(a) : 32'd0)};
        exp_q.push_back(ent);
      end
      if (is_wr && in_rng) begin
        old = model_read(a);
        for (int b = 0; b < 4; b++)
          if (bus.MByteEn[b]) old[8*b +: 8] = bus.MData[8*b +: 8];
        model_mem[a] = old;
      end
    end
  end

  // Driver: apply one cycle of master signals, return at the sampling edge.
  task automatic drive(input logic [2:0] cmd, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] be, input logic racc);
    @(posedge clk);
    #1;
    bus.MCmd        = cmd;
    bus.MAddr       = addr;
    bus.MData       = data;
    bus.MByteEn     = be;
    bus.MRespAccept = racc;
    @(negedge clk);
  endtask

  task automatic idle(input logic racc);
    drive(3'd0, 32'd0, 32'd0, 4'h0, racc);
  endtask

  initial begin
    // 1: reset held with RD on the bus
    reset           = 1'b0;
    bus.MCmd        = 3'd2;
    bus.MAddr       = 32'd3;
    bus.MData       = 32'd0;
    bus.MByteEn     = 4'h0;
    bus.MRespAccept = 1'b1;
    ram_rdata       = 32'd0;
    @(negedge clk);
    @(negedge clk);
    chk("t1_ram_en", 32'(ram_en), 32'd0);
    chk("t1_sresp",  32'(bus.SResp), 32'd0);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    bus.MCmd = 3'd0;
    @(negedge clk);
    chk("t1_credits", 32'(credits_o), 32'd4);

    // 2: write then read back
    drive(3'd1, 32'd5, 32'hDEADBEEF, 4'hF, 1'b1);
    chk("t2_wr_accept", 32'(bus.SCmdAccept), 32'd1);
    chk("t2_wr_we",     32'(ram_we), 32'd1);
    drive(3'd2, 32'd5, 32'd0, 4'h0, 1'b1);
    chk("t2_rd_accept", 32'(bus.SCmdAccept), 32'd1);
    idle(1'b1);
    chk("t2_sresp_early", 32'(bus.SResp), 32'd0);
    idle(1'b1);
    chk("t2_sresp", 32'(bus.SResp), 32'd1);
    chk("t2_sdata", bus.SData, 32'hDEADBEEF);
    idle(1'b1);
    idle(1'b1);

    // 3: byte enables
    drive(3'd1, 32'd7, 32'h11223344, 4'hF, 1'b1);
    drive(3'd1, 32'd7, 32'hAABBCCDD, 4'h3, 1'b1);
    drive(3'd2, 32'd7, 32'd0, 4'h0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("t3_sdata", bus.SData, 32'h1122CCDD);
    idle(1'b1);

    // 4: back-pressure fills credits, then drain back to back
    for (int i = 0; i < 6; i++) begin
      drive(3'd2, 32'(i), 32'd0, 4'h0, 1'b0);
      chk($sformatf("t4_accept_%0d", i), 32'(bus.SCmdAccept), (i < 4) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      idle(1'b0);
      chk("t4_hold_sresp", 32'(bus.SResp), 32'd1);
      chk("t4_hold_sdata", bus.SData, 32'h1000_0000);
    end
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      chk($sformatf("t4_drain_sresp_%0d", i), 32'(bus.SResp), 32'd1);
      chk($sformatf("t4_drain_sdata_%0d", i), bus.SData, 32'h1000_0000 + 32'(i));
    end
    drive(3'd2, 32'd4, 32'd0, 4'h0, 1'b1);
    chk("t4_fifth_accept", 32'(bus.SCmdAccept), 32'd1);
    drive(3'd2, 32'd5, 32'd0, 4'h0, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // 5: out-of-range read between two good ones
    drive(3'd2, 32'd1, 32'd0, 4'h0, 1'b1);
    drive(3'd2, 32'd4096, 32'd0, 4'h0, 1'b1);
    chk("t5_oor_accept", 32'(bus.SCmdAccept), 32'd1);
    chk("t5_oor_ram_en", 32'(ram_en), 32'd0);
    drive(3'd2, 32'd2, 32'd0, 4'h0, 1'b1);
    chk("t5_r0_sresp", 32'(bus.SResp), 32'd1);
    chk("t5_r0_sdata", bus.SData, 32'h1000_0001);
    idle(1'b1);
    chk("t5_r1_sresp", 32'(bus.SResp), 32'd3);
    chk("t5_r1_sdata", bus.SData, 32'd0);
    idle(1'b1);
    chk("t5_r2_sresp", 32'(bus.SResp), 32'd1);
    chk("t5_r2_sdata", bus.SData, 32'h1000_0002);
    idle(1'b1);
    idle(1'b1);

    // 6: reset with responses queued
    drive(3'd2, 32'd10, 32'd0, 4'h0, 1'b0);
    drive(3'd2, 32'd11, 32'd0, 4'h0, 1'b0);
    drive(3'd2, 32'd12, 32'd0, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b0);
    chk("t6_queued_sresp", 32'(bus.SResp), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_sresp",   32'(bus.SResp), 32'd0);
    chk("t6_async_credits", 32'(credits_o), 32'd4);
    idle(1'b1);
    idle(1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) idle(1'b1);
    chk("t6_no_stale_sresp", 32'(bus.SResp), 32'd0);
    chk("t6_credits_after",  32'(credits_o), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
